// File: rtl/instmem_pkg.sv
// instmem_pkg: shared constants and types for the loadable instruction memory.
//   NOP      - instruction returned for faulting fetches (addi x0,x0,0).
//   state_e  - fetch controller states LOAD / RUN / DRAIN.
//   WORD_W   - stored word width (33 with the parity bit, 32 without).
//   parity32 - even-parity bit of a 32-bit word (INSTMEM_PARITY_EN only).
// Optional feature macro: INSTMEM_PARITY_EN.
package instmem_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

`ifdef INSTMEM_PARITY_EN
  localparam int WORD_W = 33;

  // Bit that makes the total number of ones in {p, w} even.
  function automatic logic parity32(input logic [31:0] w);
    return ^w;
  endfunction
`else
  localparam int WORD_W = 32;
`endif

endpackage

// File: rtl/instmem_array.sv
// instmem_array: DEPTH x WORD_W storage, synchronous write, combinational read.
// The array has no reset; contents are undefined until written.
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write word index
//   wdata - write word (with parity bit when INSTMEM_PARITY_EN is defined)
//   raddr - read word index
//   rdata - read word
module instmem_array
  import instmem_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/instmem_fetch.sv
// instmem_fetch: loadable instruction memory with a pipelined valid/ready
// fetch port. A LOAD/RUN/DRAIN controller gates writes and fetches; fetch
// results travel through LATENCY (1 or 2) stages that shift together.
// Optional feature macro: INSTMEM_PARITY_EN (stored even parity, checked on
// read; a mismatch reports a fault with a NOP instruction).
// Ports:
//   clk, clrn            - clock, async active-low reset
//   ld_en                - request load mode
//   ld_we/ld_addr/ld_data - program write port (LOAD state only)
//   req_valid/req_ready/req_addr - fetch request handshake, byte address
//   rsp_valid/rsp_ready/rsp_inst/rsp_fault - fetch response handshake
//   flush                - drop every in-flight fetch
//   busy                 - controller is not in RUN
module instmem_fetch
  import instmem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        ld_en,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_inst,
  output logic        rsp_fault,
  input  logic        flush,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);

  if (LATENCY < 1 || LATENCY > 2) begin : g_bad_latency
    $error("instmem_fetch: LATENCY must be 1 or 2");
  end
  if (DEPTH < 16 || DEPTH > 4096 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("instmem_fetch: DEPTH must be a power of two in 16..4096");
  end

  state_e state_q, state_d;

  // Stage LATENCY-1 is the one presented on the response port.
  logic [LATENCY-1:0]       vld_q, vld_d;
  logic [LATENCY-1:0][31:0] inst_q, inst_d;
  logic [LATENCY-1:0]       fault_q, fault_d;

  logic              advance, accept;
  logic              wr_en, addr_fault, rd_fault;
  logic [WORD_W-1:0] wr_word, rd_word;
  logic [31:0]       rd_inst;
  logic              unused_bits;

  // Byte-offset bits of the load address carry no information.
  assign unused_bits = ^ld_addr[1:0];

  assign wr_en = (state_q == LOAD) && ld_we && !(|ld_addr[31:AW+2]);

`ifdef INSTMEM_PARITY_EN
  assign wr_word  = {parity32(ld_data), ld_data};
  assign rd_fault = addr_fault || (rd_word[32] != parity32(rd_word[31:0]));
`else
  assign wr_word  = ld_data;
  assign rd_fault = addr_fault;
`endif

  instmem_array #(.DEPTH(DEPTH)) u_array (
    .clk  (clk),
    .we   (wr_en),
    .waddr(ld_addr[AW+1:2]),
    .wdata(wr_word),
    .raddr(req_addr[AW+1:2]),
    .rdata(rd_word)
  );

  // Faulting fetches never expose array data: the index above is truncated
  // and its word is replaced by the NOP.
  assign addr_fault = (|req_addr[1:0]) || (|req_addr[31:AW+2]);
  assign rd_inst    = rd_fault ? NOP : rd_word[31:0];

  assign rsp_valid = vld_q[LATENCY-1];
  assign rsp_inst  = inst_q[LATENCY-1];
  assign rsp_fault = fault_q[LATENCY-1];
  assign busy      = (state_q != RUN);

  assign advance   = !rsp_valid || rsp_ready;
  assign req_ready = (state_q == RUN) && advance && !flush;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (!ld_en) state_d = RUN;
      RUN:     if (ld_en) state_d = DRAIN;
      // Falling ld_en wins over an empty pipe: the fetch side resumes.
      DRAIN:   if (!ld_en) state_d = RUN;
               else if (vld_q == '0) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Stages shift in lockstep so bubbles are preserved; flush only kills
  // valids and leaves data registers as they were.
  always_comb begin
    vld_d   = vld_q;
    inst_d  = inst_q;
    fault_d = fault_q;
    if (flush) begin
      vld_d = '0;
    end else if (advance) begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        vld_d[i]   = vld_q[i-1];
        inst_d[i]  = inst_q[i-1];
        fault_d[i] = fault_q[i-1];
      end
      vld_d[0] = accept;
      if (accept) begin
        inst_d[0]  = rd_inst;
        fault_d[0] = rd_fault;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= LOAD;
      vld_q   <= '0;
      inst_q  <= '0;
      fault_q <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_instmem_fetch.sv
// Bench for instmem_fetch: one instance per LATENCY (index 0 -> 1, 1 -> 2),
// each with its own stimulus signals, checked against a word-array model.
module tb_instmem_fetch;

  localparam int DEPTH = 64;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic clrn;
  logic        ld_en[2], ld_we[2], req_valid[2], rsp_ready[2], flush[2];
  logic        req_ready[2], rsp_valid[2], rsp_fault[2], busy[2];
  logic [31:0] ld_addr[2], ld_data[2], req_addr[2], rsp_inst[2];

  int checks = 0;
  int failures = 0;

  logic [31:0] mem_m [2][DEPTH];
  logic [31:0] wl [4];
  logic [31:0] s_addr[$];
  logic [31:0] rx_i[$];
  logic        rx_f[$];
  int acc_cyc, rsp_cyc;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    instmem_fetch #(.DEPTH(DEPTH), .LATENCY(g + 1)) u_dut (
      .clk(clk), .clrn(clrn),
      .ld_en(ld_en[g]), .ld_we(ld_we[g]), .ld_addr(ld_addr[g]), .ld_data(ld_data[g]),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_addr(req_addr[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_inst(rsp_inst[g]),
      .rsp_fault(rsp_fault[g]), .flush(flush[g]), .busy(busy[g])
    );
  end

  // Expected response for a fetch address under the current memory model.
  function automatic logic [32:0] exp_of(input int d, input logic [31:0] a);
    logic [31:0] w;
    w = a / 4;
    if ((a % 4) != 0 || w >= DEPTH) return {1'b1, NOP};
    return {1'b0, mem_m[d][w]};
  endfunction

  // A response stalled under rsp_ready=0 must reappear unchanged next cycle.
  logic        hold_v[2];
  logic [31:0] hold_i[2];
  logic        hold_f[2];
  initial begin
    hold_v[0] = 1'b0; hold_v[1] = 1'b0;
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!clrn) begin
          hold_v[d] = 1'b0;
        end else begin
          if (hold_v[d]) begin
            checks++;
            if (rsp_valid[d] !== 1'b1 || rsp_inst[d] !== hold_i[d] || rsp_fault[d] !== hold_f[d]) begin
              failures++;
              $display("FAIL hold_stable[%0d] got v=%b i=%h f=%b exp v=1 i=%h f=%b",
                       d, rsp_valid[d], rsp_inst[d], rsp_fault[d], hold_i[d], hold_f[d]);
            end
          end
          hold_v[d] = rsp_valid[d] && !rsp_ready[d] && !flush[d];
          hold_i[d] = rsp_inst[d];
          hold_f[d] = rsp_fault[d];
        end
      end
    end
  end

  // Drives the s_addr list into DUT d with random gaps and backpressure and
  // collects every handshaken response.
  task automatic stream(input int d, input int rdy_pct, input int vld_pct);
    int n, nxt, quiet, cyc;
    bit hs;
    n = s_addr.size(); nxt = 0; quiet = 0; cyc = 0; hs = 0;
    rx_i.delete(); rx_f.delete(); acc_cyc = -1; rsp_cyc = -1;
    while (cyc < 2000) begin
      @(negedge clk); cyc++;
      if (hs) nxt++;
      req_valid[d] = (nxt < n) && ($urandom_range(99) < vld_pct);
      req_addr[d]  = (nxt < n) ? s_addr[nxt] : $urandom;
      rsp_ready[d] = ($urandom_range(99) < rdy_pct);
      #1;
      hs = req_valid[d] && req_ready[d];
      if (hs && acc_cyc < 0) acc_cyc = cyc;
      if (rsp_valid[d] && rsp_cyc < 0) rsp_cyc = cyc;
      if (rsp_valid[d] && rsp_ready[d]) begin
        rx_i.push_back(rsp_inst[d]);
        rx_f.push_back(rsp_fault[d]);
      end
      quiet = (nxt + int'(hs) >= n && !rsp_valid[d] && !hs) ? quiet + 1 : 0;
      if (quiet > 4) break;
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
  endtask

  task automatic ld_write(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      ld_we[d] = 1'b1; ld_addr[d] = a; ld_data[d] = v;
      if (a / 4 < DEPTH) mem_m[d][a / 4] = v;
    end
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      ld_en[d] = 1'b1; ld_we[d] = 1'b0; ld_addr[d] = '0; ld_data[d] = '0;
      req_valid[d] = 1'b0; req_addr[d] = '0; rsp_ready[d] = 1'b0; flush[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (req_ready[d] !== 1'b0 || rsp_valid[d] !== 1'b0 || rsp_inst[d] !== 32'h0 ||
          rsp_fault[d] !== 1'b0 || busy[d] !== 1'b1) begin
        failures++;
        $display("FAIL reset[%0d] got rr=%b v=%b i=%h f=%b busy=%b exp rr=0 v=0 i=0 f=0 busy=1",
                 d, req_ready[d], rsp_valid[d], rsp_inst[d], rsp_fault[d], busy[d]);
      end
    end
    clrn = 1'b1;
  endtask

  task automatic test_load();
    wl[0] = 32'h0010_0093; wl[1] = 32'h0020_0113; wl[2] = 32'h0030_8193; wl[3] = 32'h0041_0213;
    for (int i = 0; i < DEPTH; i++) ld_write(32'(4 * i), (i < 4) ? wl[i] : $urandom);
    ld_write(32'(4 * DEPTH), 32'hDEAD_BEEF);      // beyond the array: dropped
    ld_write(32'h8000_0000, 32'hBAAD_F00D);       // high bits set: dropped
    ld_write(32'(4 * 5 + 3), $urandom);           // byte offset ignored -> word 5
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      ld_we[d] = 1'b0; ld_en[d] = 1'b0; rsp_ready[d] = 1'b1;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (busy[d] !== 1'b1 || req_ready[d] !== 1'b0) begin
        failures++;
        $display("FAIL load_still[%0d] got busy=%b rr=%b exp busy=1 rr=0", d, busy[d], req_ready[d]);
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (busy[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
        failures++;
        $display("FAIL load_to_run[%0d] got busy=%b rr=%b exp busy=0 rr=1", d, busy[d], req_ready[d]);
      end
    end
  endtask

  // A write strobe in RUN must leave the array alone; word 2 is fetched later.
  task automatic test_ignore_we();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      ld_we[d] = 1'b1; ld_addr[d] = 32'h8; ld_data[d] = ~wl[2];
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) ld_we[d] = 1'b0;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    rsp_ready[0] = 1'b1; req_valid[0] = 1'b1; req_addr[0] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid[0] !== 1'b1 || rsp_inst[0] !== wl[i] || rsp_fault[0] !== 1'b0) begin
        failures++;
        $display("FAIL b2b[%0d] got v=%b i=%h f=%b exp v=1 i=%h f=0",
                 i, rsp_valid[0], rsp_inst[0], rsp_fault[0], wl[i]);
      end
      if (i < 2) req_addr[0] = 32'(4 * (i + 1));
      else req_valid[0] = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (rsp_valid[0] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end got v=%b exp v=0", rsp_valid[0]);
    end
  endtask

  task automatic test_stall();
    int nxt, stall, cyc, extra;
    bit first, hs;
    logic [31:0] got[$];
    nxt = 0; stall = 0; cyc = 0; first = 0; hs = 0; extra = 0;
    while (cyc < 60 && got.size() < 4) begin
      @(negedge clk); cyc++;
      if (hs) nxt++;
      req_valid[1] = (nxt < 4);
      req_addr[1]  = 32'(4 * nxt);
      if (!first && rsp_valid[1]) begin first = 1; stall = 3; end
      rsp_ready[1] = (stall == 0);
      #1;
      if (stall > 0) begin
        checks++;
        if (rsp_valid[1] !== 1'b1 || rsp_inst[1] !== wl[0] || req_ready[1] !== 1'b0) begin
          failures++;
          $display("FAIL stall_hold got v=%b i=%h rr=%b exp v=1 i=%h rr=0",
                   rsp_valid[1], rsp_inst[1], req_ready[1], wl[0]);
        end
        stall--;
      end
      hs = req_valid[1] && req_ready[1];
      if (rsp_valid[1] && rsp_ready[1]) got.push_back(rsp_inst[1]);
    end
    req_valid[1] = 1'b0; rsp_ready[1] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid[1]) extra++;
    end
    checks++;
    if (got.size() != 4 || extra != 0) begin
      failures++;
      $display("FAIL stall_count got=%0d extra=%0d exp=4 extra=0", got.size(), extra);
    end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      checks++;
      if (got[i] !== wl[i]) begin
        failures++;
        $display("FAIL stall_order[%0d] got=%h exp=%h", i, got[i], wl[i]);
      end
    end
  endtask

  // Checks the collected stream against the model for DUT d.
  task automatic check_stream(input int d, input string name);
    logic [32:0] e;
    checks++;
    if (rx_i.size() != s_addr.size()) begin
      failures++;
      $display("FAIL %s_count[%0d] got=%0d exp=%0d", name, d, rx_i.size(), s_addr.size());
    end
    checks++;
    if (rsp_cyc - acc_cyc != d + 1) begin
      failures++;
      $display("FAIL %s_latency[%0d] got=%0d exp=%0d", name, d, rsp_cyc - acc_cyc, d + 1);
    end
    for (int i = 0; i < rx_i.size() && i < s_addr.size(); i++) begin
      e = exp_of(d, s_addr[i]);
      checks++;
      if (rx_i[i] !== e[31:0] || rx_f[i] !== e[32]) begin
        failures++;
        $display("FAIL %s[%0d.%0d] addr=%h got i=%h f=%b exp i=%h f=%b",
                 name, d, i, s_addr[i], rx_i[i], rx_f[i], e[31:0], e[32]);
      end
    end
  endtask

  task automatic test_fault();
    for (int d = 0; d < 2; d++) begin
      s_addr.delete();
      s_addr.push_back(32'h2);
      s_addr.push_back(32'(4 * DEPTH));
      s_addr.push_back(32'h4);
      s_addr.push_back(32'hFFFF_FFFC);
      s_addr.push_back(32'h1);
      s_addr.push_back(32'(4 * (DEPTH - 1)));
      stream(d, 100, 100);
      check_stream(d, "fault");
    end
  endtask

  task automatic test_flush();
    int seen;
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      rsp_ready[d] = 1'b0; req_valid[d] = 1'b1; req_addr[d] = 32'h0;
      @(negedge clk);
      req_addr[d] = 32'h4;
      @(negedge clk);
      req_valid[d] = 1'b0; flush[d] = 1'b1;
      #1;
      checks++;
      if (req_ready[d] !== 1'b0 || rsp_valid[d] !== 1'b1) begin
        failures++;
        $display("FAIL flush_pre[%0d] got rr=%b v=%b exp rr=0 v=1", d, req_ready[d], rsp_valid[d]);
      end
      @(negedge clk);
      flush[d] = 1'b0; rsp_ready[d] = 1'b1;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
        if (rsp_valid[d]) seen++;
        @(negedge clk);
      end
      checks++;
      if (seen != 0) begin
        failures++;
        $display("FAIL flush_stale[%0d] got=%0d exp=0", d, seen);
      end
      // flush together with rsp_ready while a request is offered
      req_valid[d] = 1'b1; req_addr[d] = 32'h8;
      @(negedge clk);
      req_valid[d] = 1'b0;
      for (int k = 0; k < 8 && !rsp_valid[d]; k++) @(negedge clk);
      flush[d] = 1'b1; rsp_ready[d] = 1'b1; req_valid[d] = 1'b1; req_addr[d] = 32'hC;
      #1;
      checks++;
      if (rsp_valid[d] !== 1'b1 || req_ready[d] !== 1'b0) begin
        failures++;
        $display("FAIL flush_ready[%0d] got v=%b rr=%b exp v=1 rr=0", d, rsp_valid[d], req_ready[d]);
      end
      @(negedge clk);
      flush[d] = 1'b0; req_valid[d] = 1'b0;
      checks++;
      if (rsp_valid[d] !== 1'b0) begin
        failures++;
        $display("FAIL flush_after[%0d] got v=%b exp v=0", d, rsp_valid[d]);
      end
      s_addr.delete();
      s_addr.push_back(32'h10);
      stream(d, 100, 100);
      check_stream(d, "flush_next");
    end
  endtask

  task automatic test_drain();
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      rsp_ready[d] = 1'b0; req_valid[d] = 1'b1; req_addr[d] = 32'h4;
      @(negedge clk);
      req_valid[d] = 1'b0; ld_en[d] = 1'b1;
      @(negedge clk);
      req_valid[d] = 1'b1; req_addr[d] = 32'h0;
      #1;
      checks++;
      if (busy[d] !== 1'b1 || req_ready[d] !== 1'b0 || rsp_valid[d] !== 1'b1 || rsp_inst[d] !== mem_m[d][1]) begin
        failures++;
        $display("FAIL drain_inflight[%0d] got busy=%b rr=%b v=%b i=%h exp busy=1 rr=0 v=1 i=%h",
                 d, busy[d], req_ready[d], rsp_valid[d], rsp_inst[d], mem_m[d][1]);
      end
      req_valid[d] = 1'b0; rsp_ready[d] = 1'b1;
      repeat (2) @(negedge clk);
      ld_we[d] = 1'b1; ld_addr[d] = 32'h0; ld_data[d] = 32'h0000_0073;
      mem_m[d][0] = 32'h0000_0073;
      @(negedge clk);
      ld_we[d] = 1'b0; ld_en[d] = 1'b0;
      @(negedge clk);
      checks++;
      if (busy[d] !== 1'b0 || rsp_valid[d] !== 1'b0) begin
        failures++;
        $display("FAIL drain_run[%0d] got busy=%b v=%b exp busy=0 v=0", d, busy[d], rsp_valid[d]);
      end
      s_addr.delete();
      s_addr.push_back(32'h0);
      stream(d, 100, 100);
      check_stream(d, "drain_reload");
      // ld_en drops again while a response is still held: back to RUN
      @(negedge clk);
      rsp_ready[d] = 1'b0; req_valid[d] = 1'b1; req_addr[d] = 32'h8;
      @(negedge clk);
      req_valid[d] = 1'b0; ld_en[d] = 1'b1;
      @(negedge clk);
      checks++;
      if (busy[d] !== 1'b1) begin
        failures++;
        $display("FAIL drain_enter[%0d] got busy=%b exp busy=1", d, busy[d]);
      end
      ld_en[d] = 1'b0;
      @(negedge clk);
      checks++;
      if (busy[d] !== 1'b0 || rsp_valid[d] !== 1'b1 || rsp_inst[d] !== mem_m[d][2]) begin
        failures++;
        $display("FAIL drain_abort[%0d] got busy=%b v=%b i=%h exp busy=0 v=1 i=%h",
                 d, busy[d], rsp_valid[d], rsp_inst[d], mem_m[d][2]);
      end
      rsp_ready[d] = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    for (int d = 0; d < 2; d++) begin
      s_addr.delete();
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(4) == 0) s_addr.push_back($urandom);
        else s_addr.push_back(32'(4 * $urandom_range(DEPTH - 1)));
      end
      stream(d, 60, 70);
      check_stream(d, "random");
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      rsp_ready[d] = 1'b0; req_valid[d] = 1'b1; req_addr[d] = 32'h4;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) req_valid[d] = 1'b0;
    @(negedge clk);
    clrn = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rsp_valid[d] !== 1'b0 || busy[d] !== 1'b1 || req_ready[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid[%0d] got v=%b busy=%b rr=%b exp v=0 busy=1 rr=0",
                 d, rsp_valid[d], busy[d], req_ready[d]);
      end
    end
    @(negedge clk);
    clrn = 1'b1;
    for (int d = 0; d < 2; d++) rsp_ready[d] = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (busy[d] !== 1'b0 || rsp_valid[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_resume[%0d] got busy=%b v=%b exp busy=0 v=0", d, busy[d], rsp_valid[d]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_ignore_we();
    test_back_to_back();
    test_stall();
    test_fault();
    test_flush();
    test_drain();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
